// File: rtl/uart_tx_engine.sv
// uart_tx_engine: UART transmit serialiser between a show-ahead TX FIFO and
// a baud tick generator. One frame per popped word, with programmable data
// width, parity mode, stop-bit count and bit order. Frames run back to back
// while the FIFO holds data. State, bit counter and shift register can be
// triplicated with majority voting.
//
// Ports:
//   clk, rst         system clock, asynchronous active-low reset
//   p_BaudSig_i      one-clk baud tick; qualifies every transition
//   p_FiFoEmpty_i    FIFO empty flag
//   FiFoData_i       FIFO head word
//   p_FiFoRead_o     one-clk pop strobe
//   DataBits_i       data bits per frame (clamped to 5..MAX_DATA_BITS)
//   ParityMode_i     0 none, 1 even, 2 odd, 3 mark, 4 space, 5..7 none
//   StopBits_i       0 = one stop bit, 1 = two
//   MsbFirst_i       1 = MSB first
//   Tx_o             serial line, idle high
//   State_o          one-hot voted state
//   BitCounter_o     voted data-bit index
//   Busy_o           high outside INTERVAL
//   p_FrameDone_o    one-clk pulse on the final stop-bit tick
//
// state     | meaning
// INTERVAL  | idle, line high, waiting for data and a tick
// STARTBIT  | start bit on the line
// DATABITS  | data bit BitCounter on the line
// PARITYBIT | parity bit on the line
// STOPBIT1  | first stop bit
// STOPBIT2  | second stop bit (two-stop-bit frames only)
module uart_tx_engine #(
    parameter int MAX_DATA_BITS = 9,
    parameter bit TMR_EN        = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     p_BaudSig_i,
    input  logic                     p_FiFoEmpty_i,
    input  logic [MAX_DATA_BITS-1:0] FiFoData_i,
    output logic                     p_FiFoRead_o,
    input  logic [3:0]               DataBits_i,
    input  logic [2:0]               ParityMode_i,
    input  logic                     StopBits_i,
    input  logic                     MsbFirst_i,
    output logic                     Tx_o,
    output logic [5:0]               State_o,
    output logic [3:0]               BitCounter_o,
    output logic                     Busy_o,
    output logic                     p_FrameDone_o
);

    typedef enum logic [5:0] {
        S_INTERVAL  = 6'b000001,
        S_STARTBIT  = 6'b000010,
        S_DATABITS  = 6'b000100,
        S_PARITYBIT = 6'b001000,
        S_STOPBIT1  = 6'b010000,
        S_STOPBIT2  = 6'b100000
    } state_t;

    localparam logic [3:0] MIN_N = 4'd5;
    localparam logic [3:0] MAX_N = 4'(MAX_DATA_BITS);

    logic [5:0]               state_v, state_nx;
    logic [3:0]               cnt_v, cnt_nx;
    logic [MAX_DATA_BITS-1:0] shift_v, shift_nx, shift_adv;
    logic                     tx_q, tx_nx;
    logic                     par_acc_q, par_acc_nx;
    logic [3:0]               n_q, n_nx, n_in;
    logic [2:0]               pmode_q, pmode_nx;
    logic                     stop2_q, stop2_nx;
    logic                     msb_q, msb_nx;
    logic                     armed_q;
    logic                     tick, cur_bit, par_en, par_bit;
    logic                     start, last;

    // A tick on the first edge after reset release is discarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) armed_q <= 1'b0;
        else      armed_q <= 1'b1;
    end

    generate
        if (TMR_EN) begin : g_tmr
            logic [5:0]               state_a, state_b, state_c;
            logic [3:0]               cnt_a, cnt_b, cnt_c;
            logic [MAX_DATA_BITS-1:0] shift_a, shift_b, shift_c;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_a <= S_INTERVAL;
                    state_b <= S_INTERVAL;
                    state_c <= S_INTERVAL;
                    cnt_a   <= '0;
                    cnt_b   <= '0;
                    cnt_c   <= '0;
                    shift_a <= '0;
                    shift_b <= '0;
                    shift_c <= '0;
                end else begin
                    state_a <= state_nx;
                    state_b <= state_nx;
                    state_c <= state_nx;
                    cnt_a   <= cnt_nx;
                    cnt_b   <= cnt_nx;
                    cnt_c   <= cnt_nx;
                    shift_a <= shift_nx;
                    shift_b <= shift_nx;
                    shift_c <= shift_nx;
                end
            end

            assign state_v = (state_a & state_b) | (state_a & state_c) | (state_b & state_c);
            assign cnt_v   = (cnt_a & cnt_b) | (cnt_a & cnt_c) | (cnt_b & cnt_c);
            assign shift_v = (shift_a & shift_b) | (shift_a & shift_c) | (shift_b & shift_c);
        end else begin : g_single
            logic [5:0]               state_a;
            logic [3:0]               cnt_a;
            logic [MAX_DATA_BITS-1:0] shift_a;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_a <= S_INTERVAL;
                    cnt_a   <= '0;
                    shift_a <= '0;
                end else begin
                    state_a <= state_nx;
                    cnt_a   <= cnt_nx;
                    shift_a <= shift_nx;
                end
            end

            assign state_v = state_a;
            assign cnt_v   = cnt_a;
            assign shift_v = shift_a;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_q      <= 1'b1;
            par_acc_q <= 1'b0;
            n_q       <= MIN_N;
            pmode_q   <= 3'd0;
            stop2_q   <= 1'b0;
            msb_q     <= 1'b0;
        end else begin
            tx_q      <= tx_nx;
            par_acc_q <= par_acc_nx;
            n_q       <= n_nx;
            pmode_q   <= pmode_nx;
            stop2_q   <= stop2_nx;
            msb_q     <= msb_nx;
        end
    end

    always_comb begin
        tick = p_BaudSig_i & armed_q;

        if (DataBits_i < MIN_N)      n_in = MIN_N;
        else if (DataBits_i > MAX_N) n_in = MAX_N;
        else                         n_in = DataBits_i;

        cur_bit   = msb_q ? shift_v[n_q - 4'd1] : shift_v[0];
        shift_adv = msb_q ? (shift_v << 1) : (shift_v >> 1);
        par_en    = (pmode_q >= 3'd1) && (pmode_q <= 3'd4);

        // par_acc_q already holds the XOR of every data bit sent.
        case (pmode_q)
            3'd1:    par_bit = par_acc_q;
            3'd2:    par_bit = ~par_acc_q;
            3'd3:    par_bit = 1'b1;
            default: par_bit = 1'b0;
        endcase

        state_nx      = state_v;
        cnt_nx        = cnt_v;
        shift_nx      = shift_v;
        tx_nx         = tx_q;
        par_acc_nx    = par_acc_q;
        n_nx          = n_q;
        pmode_nx      = pmode_q;
        stop2_nx      = stop2_q;
        msb_nx        = msb_q;
        start         = 1'b0;
        last          = 1'b0;
        p_FiFoRead_o  = 1'b0;
        p_FrameDone_o = 1'b0;

        case (state_v)
            S_INTERVAL: begin
                tx_nx  = 1'b1;
                cnt_nx = '0;
                if (tick && !p_FiFoEmpty_i) start = 1'b1;
            end
            S_STARTBIT: begin
                if (tick) begin
                    state_nx   = S_DATABITS;
                    cnt_nx     = '0;
                    tx_nx      = cur_bit;
                    par_acc_nx = par_acc_q ^ cur_bit;
                    shift_nx   = shift_adv;
                end
            end
            S_DATABITS: begin
                if (tick) begin
                    if (cnt_v < n_q - 4'd1) begin
                        cnt_nx     = cnt_v + 4'd1;
                        tx_nx      = cur_bit;
                        par_acc_nx = par_acc_q ^ cur_bit;
                        shift_nx   = shift_adv;
                    end else begin
                        cnt_nx = '0;
                        if (par_en) begin
                            state_nx = S_PARITYBIT;
                            tx_nx    = par_bit;
                        end else begin
                            state_nx = S_STOPBIT1;
                            tx_nx    = 1'b1;
                        end
                    end
                end
            end
            S_PARITYBIT: begin
                if (tick) begin
                    state_nx = S_STOPBIT1;
                    tx_nx    = 1'b1;
                end
            end
            S_STOPBIT1: begin
                if (tick) begin
                    if (stop2_q) begin
                        state_nx = S_STOPBIT2;
                        tx_nx    = 1'b1;
                    end else begin
                        last = 1'b1;
                    end
                end
            end
            S_STOPBIT2: begin
                if (tick) last = 1'b1;
            end
            default: begin
                // Voted state is not one-hot: recover to idle.
                state_nx = S_INTERVAL;
                tx_nx    = 1'b1;
                cnt_nx   = '0;
            end
        endcase

        if (last) begin
            p_FrameDone_o = 1'b1;
            if (!p_FiFoEmpty_i) begin
                start = 1'b1;
            end else begin
                state_nx = S_INTERVAL;
                tx_nx    = 1'b1;
            end
        end

        if (start) begin
            state_nx     = S_STARTBIT;
            p_FiFoRead_o = 1'b1;
            shift_nx     = FiFoData_i;
            n_nx         = n_in;
            pmode_nx     = ParityMode_i;
            stop2_nx     = StopBits_i;
            msb_nx       = MsbFirst_i;
            par_acc_nx   = 1'b0;
            tx_nx        = 1'b0;
            cnt_nx       = '0;
        end
    end

    assign Tx_o         = tx_q;
    assign State_o      = state_v;
    assign BitCounter_o = cnt_v;
    assign Busy_o       = (state_v != S_INTERVAL);

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: a queue-backed show-ahead FIFO and a
// divide-by-DIV baud tick generator surround the DUT; Tx_o, State_o,
// BitCounter_o and Busy_o are checked after every tick against hand-written
// bit sequences.
module tb_uart_tx_engine;
    localparam int W   = 9;
    localparam int DIV = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         p_BaudSig_i = 1'b0;
    logic         p_FiFoEmpty_i = 1'b1;
    logic [W-1:0] FiFoData_i = '0;
    logic         p_FiFoRead_o;
    logic [3:0]   DataBits_i = 4'd8;
    logic [2:0]   ParityMode_i = 3'd0;
    logic         StopBits_i = 1'b0;
    logic         MsbFirst_i = 1'b0;
    logic         Tx_o;
    logic [5:0]   State_o;
    logic [3:0]   BitCounter_o;
    logic         Busy_o;
    logic         p_FrameDone_o;

    int           n_pass = 0;
    int           n_total = 0;
    int           pop_count = 0;
    int           pops0 = 0;
    logic [W-1:0] fifo_q[$];
    logic         tick_en = 1'b0;
    int           div_cnt = 0;
    logic         pop_pend = 1'b0;
    logic         last_done = 1'b0;
    logic         last_rd = 1'b0;

    uart_tx_engine #(.MAX_DATA_BITS(W), .TMR_EN(1'b1)) dut (
        .clk(clk),
        .rst(rst),
        .p_BaudSig_i(p_BaudSig_i),
        .p_FiFoEmpty_i(p_FiFoEmpty_i),
        .FiFoData_i(FiFoData_i),
        .p_FiFoRead_o(p_FiFoRead_o),
        .DataBits_i(DataBits_i),
        .ParityMode_i(ParityMode_i),
        .StopBits_i(StopBits_i),
        .MsbFirst_i(MsbFirst_i),
        .Tx_o(Tx_o),
        .State_o(State_o),
        .BitCounter_o(BitCounter_o),
        .Busy_o(Busy_o),
        .p_FrameDone_o(p_FrameDone_o)
    );

    always #5 clk = ~clk;

    // FIFO and baud generator: pop decided before the edge, inputs
    // updated 1 time unit after it.
    always begin
        @(negedge clk);
        pop_pend = p_FiFoRead_o;
        @(posedge clk);
        #1;
        if (pop_pend) begin
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            pop_count++;
        end
        p_FiFoEmpty_i = (fifo_q.size() == 0);
        FiFoData_i    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        if (tick_en) begin
            div_cnt     = (div_cnt == DIV - 1) ? 0 : div_cnt + 1;
            p_BaudSig_i = (div_cnt == DIV - 1);
        end else begin
            div_cnt     = 0;
            p_BaudSig_i = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Returns 1 time unit after the next baud-tick edge.
    task automatic wait_tick();
        int n = 0;
        @(negedge clk);
        while (!p_BaudSig_i && n < 4 * DIV) begin
            @(negedge clk);
            n++;
        end
        if (!p_BaudSig_i) begin
            n_total++;
            $error("FAIL tick_timeout observed=no_tick expected=baud_tick");
        end
        last_done = p_FrameDone_o;
        last_rd   = p_FiFoRead_o;
        @(posedge clk);
        #1;
    endtask

    // Called with the start bit already on the line. txv[i] is the line
    // value during bit period i.
    task automatic run_frame(input string tag, input logic [15:0] txv, input int len,
                             input int nb, input bit pe, input bit more);
        logic [5:0] es;
        int         j;
        for (int i = 0; i < len; i++) begin
            if (i > 0) begin
                wait_tick();
                check($sformatf("%s_done_early%0d", tag, i), 32'(last_done), 32'd0);
            end
            if (i == 0) es = 6'b000010;
            else if (i <= nb) es = 6'b000100;
            else begin
                j = i - nb - 1;
                if (pe && j == 0) es = 6'b001000;
                else begin
                    if (pe) j--;
                    es = (j == 0) ? 6'b010000 : 6'b100000;
                end
            end
            check($sformatf("%s_tx%0d", tag, i), 32'(Tx_o), 32'(txv[i]));
            check($sformatf("%s_st%0d", tag, i), 32'(State_o), 32'(es));
            check($sformatf("%s_cnt%0d", tag, i), 32'(BitCounter_o),
                  (i >= 1 && i <= nb) ? 32'(i - 1) : 32'd0);
            check($sformatf("%s_busy%0d", tag, i), 32'(Busy_o), 32'd1);
            repeat (DIV / 2) @(negedge clk);
            check($sformatf("%s_hold%0d", tag, i), 32'(Tx_o), 32'(txv[i]));
        end
        wait_tick();
        check({tag, "_done"}, 32'(last_done), 32'd1);
        check({tag, "_next_pop"}, 32'(last_rd), 32'(more));
        check({tag, "_end_st"}, 32'(State_o), more ? 32'h02 : 32'h01);
        check({tag, "_end_tx"}, 32'(Tx_o), more ? 32'd0 : 32'd1);
    endtask

    initial begin
        #23;
        check("rst_state", 32'(State_o), 32'h01);
        check("rst_tx", 32'(Tx_o), 32'd1);
        check("rst_cnt", 32'(BitCounter_o), 32'd0);
        check("rst_busy", 32'(Busy_o), 32'd0);
        check("rst_rd", 32'(p_FiFoRead_o), 32'd0);
        check("rst_done", 32'(p_FrameDone_o), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;
        tick_en = 1'b1;

        // 8N1 LSB-first 0xA5
        pops0 = pop_count;
        fifo_q.push_back(9'h0A5);
        wait_tick();
        check("t1_pop", 32'(last_rd), 32'd1);
        run_frame("t1", 16'b1101001010, 10, 8, 1'b0, 1'b0);
        @(negedge clk);
        check("t1_pops", 32'(pop_count - pops0), 32'd1);

        // 7E2 0x41, config changed mid-frame must be ignored
        #1;
        DataBits_i = 4'd7; ParityMode_i = 3'd1; StopBits_i = 1'b1; MsbFirst_i = 1'b0;
        fifo_q.push_back(9'h041);
        wait_tick();
        check("t2_pop", 32'(last_rd), 32'd1);
        #1;
        DataBits_i = 4'd9; ParityMode_i = 3'd0; StopBits_i = 1'b0; MsbFirst_i = 1'b1;
        run_frame("t2", 16'b11010000010, 11, 7, 1'b1, 1'b0);

        // 9O1 MSB-first 0x1F0
        #1;
        DataBits_i = 4'd9; ParityMode_i = 3'd2; StopBits_i = 1'b0; MsbFirst_i = 1'b1;
        fifo_q.push_back(9'h1F0);
        wait_tick();
        check("t3_pop", 32'(last_rd), 32'd1);
        run_frame("t3", 16'b100000111110, 12, 9, 1'b1, 1'b0);

        // DataBits 3 clamps to 5, upper word bits ignored
        #1;
        DataBits_i = 4'd3; ParityMode_i = 3'd0;
        fifo_q.push_back(9'h1F6);
        wait_tick();
        check("t3b_pop", 32'(last_rd), 32'd1);
        run_frame("t3b", 16'b1011010, 7, 5, 1'b0, 1'b0);

        // three back-to-back 8N1 frames
        #1;
        DataBits_i = 4'd8; ParityMode_i = 3'd0; StopBits_i = 1'b0; MsbFirst_i = 1'b0;
        pops0 = pop_count;
        fifo_q.push_back(9'h000);
        fifo_q.push_back(9'h0FF);
        fifo_q.push_back(9'h03C);
        wait_tick();
        check("t4_pop", 32'(last_rd), 32'd1);
        run_frame("t4a", 16'b1000000000, 10, 8, 1'b0, 1'b1);
        run_frame("t4b", 16'b1111111110, 10, 8, 1'b0, 1'b1);
        run_frame("t4c", 16'b1001111000, 10, 8, 1'b0, 1'b0);
        @(negedge clk);
        check("t4_pops", 32'(pop_count - pops0), 32'd3);

        // reset during data bit 4
        #1;
        pops0 = pop_count;
        fifo_q.push_back(9'h0A5);
        fifo_q.push_back(9'h05A);
        wait_tick();
        repeat (5) wait_tick();
        check("t5_pre_st", 32'(State_o), 32'h04);
        check("t5_pre_cnt", 32'(BitCounter_o), 32'd4);
        #2;
        rst = 1'b0;
        #1;
        check("t5_rst_tx", 32'(Tx_o), 32'd1);
        check("t5_rst_st", 32'(State_o), 32'h01);
        check("t5_rst_busy", 32'(Busy_o), 32'd0);
        // release on a cycle carrying a tick; that tick must be ignored
        begin
            int n = 0;
            @(negedge clk);
            while (!p_BaudSig_i && n < 4 * DIV) begin
                @(negedge clk);
                n++;
            end
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rel_st", 32'(State_o), 32'h01);
        wait_tick();
        check("t5_pop", 32'(last_rd), 32'd1);
        run_frame("t5", 16'b1010110100, 10, 8, 1'b0, 1'b0);
        @(negedge clk);
        check("t5_pops", 32'(pop_count - pops0), 32'd2);

        // TMR: single-copy upset, then double-copy corruption
        #1;
        fifo_q.push_back(9'h0A5);
        wait_tick();
        wait_tick();
        wait_tick();
        @(negedge clk);
        force dut.g_tmr.state_b = 6'b010000;
        #1;
        check("t6_vote_st", 32'(State_o), 32'h04);
        check("t6_vote_tx", 32'(Tx_o), 32'd0);
        #1;
        release dut.g_tmr.state_b;
        @(posedge clk);
        #1;
        check("t6_fix_b", 32'(dut.g_tmr.state_b), 32'h04);
        check("t6_fix_tx", 32'(Tx_o), 32'd0);
        wait_tick();
        check("t6_bit2_tx", 32'(Tx_o), 32'd1);
        check("t6_bit2_cnt", 32'(BitCounter_o), 32'd2);
        wait_tick();
        check("t6_bit3_tx", 32'(Tx_o), 32'd0);
        @(negedge clk);
        force dut.g_tmr.state_a = 6'b000000;
        force dut.g_tmr.state_b = 6'b000000;
        @(posedge clk);
        #1;
        check("t6_bad_tx", 32'(Tx_o), 32'd1);
        check("t6_bad_c", 32'(dut.g_tmr.state_c), 32'h01);
        #1;
        release dut.g_tmr.state_a;
        release dut.g_tmr.state_b;
        @(posedge clk);
        #1;
        check("t6_rec_st", 32'(State_o), 32'h01);
        check("t6_rec_tx", 32'(Tx_o), 32'd1);
        check("t6_rec_busy", 32'(Busy_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
